// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC read-modify-write, illegal-access detection,
// performance counters and atomic trap-entry / mret updates of mstatus/mepc/mcause.
module csr_unit #(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] HARTID    = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_req_i,
  input  logic [1:0]          csr_op_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_illegal_o,
  input  logic                retire_i,
  input  logic [((NUM_HPM == 0) ? 1 : NUM_HPM)-1:0] hpm_event_i,
  input  logic                trap_i,
  input  logic [31:0]         trap_cause_i,
  input  logic [31:0]         trap_epc_i,
  input  logic                mret_i,
  output logic [31:0]         mtvec_o,
  output logic [31:0]         mepc_o,
  output logic [31:0]         mstatus_o,
  output logic [31:0]         mie_o
);

  localparam int unsigned NUM_CNT  = 3 + NUM_HPM;
  localparam logic [31:0] INH_MASK = 32'h5 | (32'((64'h1 << NUM_HPM) - 64'h1) << 3);
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_DCSR     = 12'h7B0;
  localparam logic [11:0] A_DPC      = 12'h7B1;
  localparam logic [11:0] A_DSCR0    = 12'h7B2;
  localparam logic [11:0] A_DSCR1    = 12'h7B3;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic             r_st_mie;
  logic             r_st_mpie;
  logic [31:0]      r_mie;
  logic [31:0]      r_mtvec;
  logic [31:0]      r_mscratch;
  logic [31:0]      r_mepc;
  logic [31:0]      r_mcause;
  logic [31:0]      r_mcntinh;
  logic [31:0]      r_dcsr;
  logic [31:0]      r_dpc;
  logic [31:0]      r_dscr0;
  logic [31:0]      r_dscr1;
  logic [CNT_W-1:0] r_cnt [NUM_CNT];

  logic [63:0]        w_cnt64 [NUM_CNT];
  logic [NUM_CNT-1:0] w_inc;
  logic [31:0]        w_mstatus;
  logic [31:0]        w_old;
  logic [31:0]        w_wval;
  logic               w_impl;
  logic               w_ro;
  logic               w_is_wr;
  logic               w_illegal;
  logic               w_we;
  logic               w_cnt_wr;
  logic [6:0]         w_cnt_grp;
  logic [4:0]         w_cnt_idx;
  logic               w_cnt_hi;
  logic               w_is_cnt;
  logic               w_unused_hpm;

  assign w_mstatus = 32'h1800 | (32'(r_st_mpie) << 7) | (32'(r_st_mie) << 3);

  // Counter address decode: 0xB00/0xB80 machine halves, 0xC00/0xC80 user mirrors; index 1 (time) absent.
  assign w_cnt_grp = csr_addr_i[11:5];
  assign w_cnt_idx = csr_addr_i[4:0];
  assign w_cnt_hi  = csr_addr_i[7];
  assign w_is_cnt  = (w_cnt_grp == 7'h58 || w_cnt_grp == 7'h5C ||
                      w_cnt_grp == 7'h60 || w_cnt_grp == 7'h64) && (w_cnt_idx != 5'd1);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) w_cnt64[i] = 64'(r_cnt[i]);
  end

  always_comb begin
    w_inc    = '0;
    w_inc[0] = ~r_mcntinh[0];
    w_inc[2] = retire_i & ~r_mcntinh[2];
    for (int unsigned k = 0; k < NUM_HPM; k++) w_inc[3+k] = hpm_event_i[k] & ~r_mcntinh[3+k];
  end

  // Read mux and address classification.
  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    w_ro   = 1'b0;
    case (csr_addr_i)
      A_MSTATUS:  w_old = w_mstatus;
      A_MISA:     w_old = MISA_VAL;
      A_MIE:      w_old = r_mie;
      A_MTVEC:    w_old = r_mtvec;
      A_MCNTINH:  w_old = r_mcntinh;
      A_MSCRATCH: w_old = r_mscratch;
      A_MEPC:     w_old = r_mepc;
      A_MCAUSE:   w_old = r_mcause;
      A_DCSR:     w_old = r_dcsr;
      A_DPC:      w_old = r_dpc;
      A_DSCR0:    w_old = r_dscr0;
      A_DSCR1:    w_old = r_dscr1;
      A_MVENDOR, A_MARCH, A_MIMP: w_ro = 1'b1;
      A_MHARTID: begin
        w_old = HARTID;
        w_ro  = 1'b1;
      end
      default: begin
        if (w_is_cnt) begin
          w_ro = (csr_addr_i[11:8] == 4'hC);
          for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (i != 1 && w_cnt_idx == 5'(i))
              w_old = w_cnt_hi ? w_cnt64[i][63:32] : w_cnt64[i][31:0];
          end
        end else begin
          w_impl = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    case (csr_op_i)
      2'b01:   w_wval = csr_wdata_i;
      2'b10:   w_wval = w_old | csr_wdata_i;
      2'b11:   w_wval = w_old & ~csr_wdata_i;
      default: w_wval = w_old;
    endcase
  end

  assign w_is_wr       = (csr_op_i == 2'b01) || (csr_op_i[1] && csr_wdata_i != 32'h0);
  assign w_illegal     = ~w_impl | (w_ro & w_is_wr);
  assign csr_illegal_o = csr_req_i & w_illegal;
  assign csr_rdata_o   = w_illegal ? 32'h0 : w_old;
  assign w_we          = csr_req_i & w_is_wr & ~w_illegal & ~trap_i & ~mret_i;
  assign w_cnt_wr      = w_we & w_is_cnt & ~(w_cnt_hi & (CNT_W != 64));

  assign mtvec_o   = r_mtvec;
  assign mepc_o    = r_mepc;
  assign mstatus_o = w_mstatus;
  assign mie_o     = r_mie;

  assign w_unused_hpm = ^hpm_event_i;

  // Trap entry beats mret beats CSR write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST & ~32'h2;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcntinh  <= '0;
      r_dcsr     <= '0;
      r_dpc      <= '0;
      r_dscr0    <= '0;
      r_dscr1    <= '0;
    end else if (trap_i) begin
      r_mepc    <= trap_epc_i & ~32'h3;
      r_mcause  <= trap_cause_i;
      r_st_mpie <= r_st_mie;
      r_st_mie  <= 1'b0;
    end else if (mret_i) begin
      r_st_mie  <= r_st_mpie;
      r_st_mpie <= 1'b1;
    end else if (w_we) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          r_st_mie  <= w_wval[3];
          r_st_mpie <= w_wval[7];
        end
        A_MIE:      r_mie      <= w_wval & MIE_MASK;
        A_MTVEC:    r_mtvec    <= w_wval & ~32'h2;
        A_MCNTINH:  r_mcntinh  <= w_wval & INH_MASK;
        A_MSCRATCH: r_mscratch <= w_wval;
        A_MEPC:     r_mepc     <= w_wval & ~32'h3;
        A_MCAUSE:   r_mcause   <= w_wval;
        A_DCSR:     r_dcsr     <= w_wval;
        A_DPC:      r_dpc      <= w_wval;
        A_DSCR0:    r_dscr0    <= w_wval;
        A_DSCR1:    r_dscr1    <= w_wval;
        default: ;
      endcase
    end
  end

  // A written half replaces the counter's increment for that cycle; the other half is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (w_cnt_wr && w_cnt_idx == 5'(i))
          r_cnt[i] <= CNT_W'(w_cnt_hi ? {w_wval, w_cnt64[i][31:0]} : {w_cnt64[i][63:32], w_wval});
        else if (w_inc[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: full build plus a NUM_HPM=0 / CNT_W=32 build.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] rdata, rdata2;
  logic        illegal, illegal2;
  logic        retire;
  logic [3:0]  hpm_event;
  logic        trap;
  logic [31:0] trap_cause, trap_epc;
  logic        mret;
  logic [31:0] mtvec, mepc, mstatus, mie;
  logic [31:0] mtvec2, mepc2, mstatus2, mie2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  csr_unit #(.NUM_HPM(4), .CNT_W(64), .HARTID(32'h5), .MTVEC_RST(32'h100)) dut (
    .clk(clk), .rst(rst), .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(rdata), .csr_illegal_o(illegal), .retire_i(retire),
    .hpm_event_i(hpm_event), .trap_i(trap), .trap_cause_i(trap_cause), .trap_epc_i(trap_epc),
    .mret_i(mret), .mtvec_o(mtvec), .mepc_o(mepc), .mstatus_o(mstatus), .mie_o(mie)
  );

  csr_unit #(.NUM_HPM(0), .CNT_W(32)) dut_small (
    .clk(clk), .rst(rst), .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(rdata2), .csr_illegal_o(illegal2), .retire_i(retire),
    .hpm_event_i(1'b0), .trap_i(trap), .trap_cause_i(trap_cause), .trap_epc_i(trap_epc),
    .mret_i(mret), .mtvec_o(mtvec2), .mepc_o(mepc2), .mstatus_o(mstatus2), .mie_o(mie2)
  );

  // One CSR access in one cycle: drive after negedge, capture the combinational response, commit.
  task automatic csr_cycle(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic ill);
    @(negedge clk);
    csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    #1;
    rd = rdata; ill = illegal;
    @(posedge clk);
    #1;
    csr_req = 1'b0; csr_op = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'hB00; csr_wdata = '0;
    retire = 1'b0; hpm_event = '0; trap = 1'b0; mret = 1'b0; trap_cause = '0; trap_epc = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (mstatus !== 32'h1800) $display("FAIL reset_mstatus got %h exp %h", mstatus, 32'h1800); else n_pass++;
    n_total++; if (mtvec !== 32'h100) $display("FAIL reset_mtvec got %h exp %h", mtvec, 32'h100); else n_pass++;
    n_total++; if (mepc !== 32'h0 || mie !== 32'h0) $display("FAIL reset_mepc_mie got %h/%h exp 0/0", mepc, mie); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (rdata !== 32'd3) $display("FAIL reset_mcycle got %0d exp 3", rdata); else n_pass++;
    csr_addr = 12'hB80; #1;
    n_total++; if (rdata !== 32'd0) $display("FAIL reset_mcycleh got %0d exp 0", rdata); else n_pass++;
    csr_req = 1'b0;
  endtask

  task automatic test_mie();
    logic [31:0] rd; logic ill;
    csr_cycle(2'b01, 12'h304, 32'hFFFF_FFFF, rd, ill);
    n_total++; if (rd !== 32'h0 || ill !== 1'b0) $display("FAIL mie_rw_old got %h/%b exp 0/0", rd, ill); else n_pass++;
    n_total++; if (mie !== 32'h888) $display("FAIL mie_rw got %h exp %h", mie, 32'h888); else n_pass++;
    csr_cycle(2'b11, 12'h304, 32'h8, rd, ill);
    n_total++; if (rd !== 32'h888) $display("FAIL mie_rc_old got %h exp %h", rd, 32'h888); else n_pass++;
    n_total++; if (mie !== 32'h880) $display("FAIL mie_rc got %h exp %h", mie, 32'h880); else n_pass++;
    csr_cycle(2'b10, 12'hC00, 32'h0, rd, ill);
    n_total++; if (ill !== 1'b0) $display("FAIL rs0_c00_illegal got %b exp 0", ill); else n_pass++;
    csr_cycle(2'b01, 12'h305, 32'hFFFF_FFFF, rd, ill);
    n_total++; if (mtvec !== 32'hFFFF_FFFD) $display("FAIL mtvec_mask got %h exp %h", mtvec, 32'hFFFF_FFFD); else n_pass++;
    csr_cycle(2'b01, 12'h341, 32'h1237, rd, ill);
    n_total++; if (mepc !== 32'h1234) $display("FAIL mepc_mask got %h exp %h", mepc, 32'h1234); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic ill;
    csr_cycle(2'b01, 12'hC00, 32'h5, rd, ill);
    n_total++; if (ill !== 1'b1 || rd !== 32'h0) $display("FAIL rw_c00 got %b/%h exp 1/0", ill, rd); else n_pass++;
    csr_cycle(2'b01, 12'hF11, 32'h5, rd, ill);
    n_total++; if (ill !== 1'b1 || rd !== 32'h0) $display("FAIL rw_f11 got %b/%h exp 1/0", ill, rd); else n_pass++;
    csr_cycle(2'b00, 12'h7FF, 32'h0, rd, ill);
    n_total++; if (ill !== 1'b1 || rd !== 32'h0) $display("FAIL rd_7ff got %b/%h exp 1/0", ill, rd); else n_pass++;
    csr_cycle(2'b01, 12'h304, 32'h0, rd, ill);
    n_total++; if (rd !== 32'h880) $display("FAIL illegal_state_mie got %h exp %h", rd, 32'h880); else n_pass++;
    n_total++; if (mstatus !== 32'h1800) $display("FAIL illegal_state_mstatus got %h exp %h", mstatus, 32'h1800); else n_pass++;
    csr_cycle(2'b00, 12'hF14, 32'h0, rd, ill);
    n_total++; if (ill !== 1'b0 || rd !== 32'h5) $display("FAIL mhartid got %b/%h exp 0/5", ill, rd); else n_pass++;
    csr_cycle(2'b01, 12'h301, 32'h0, rd, ill);
    n_total++; if (ill !== 1'b0 || rd !== 32'h4000_1100) $display("FAIL misa_wr got %b/%h exp 0/40001100", ill, rd); else n_pass++;
    csr_cycle(2'b00, 12'h301, 32'h0, rd, ill);
    n_total++; if (rd !== 32'h4000_1100) $display("FAIL misa_keep got %h exp %h", rd, 32'h4000_1100); else n_pass++;
  endtask

  task automatic test_counters();
    logic [31:0] rd, v; logic ill;
    csr_cycle(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, ill);
    csr_cycle(2'b01, 12'hB80, 32'h0, rd, ill);
    // Increment was dropped on the high-half write, so low stays all-ones for one more cycle.
    @(negedge clk);
    csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'hB00; #1;
    n_total++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL mcycle_drop got %h exp ffffffff", rdata); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (rdata !== 32'h0) $display("FAIL mcycle_wrap_lo got %h exp 0", rdata); else n_pass++;
    csr_addr = 12'hB80; #1;
    n_total++; if (rdata !== 32'h1) $display("FAIL mcycle_wrap_hi got %h exp 1", rdata); else n_pass++;
    csr_req = 1'b0;
    csr_cycle(2'b01, 12'h320, 32'h1, rd, ill);
    csr_cycle(2'b00, 12'hB00, 32'h0, v, ill);
    repeat (3) @(posedge clk);
    csr_cycle(2'b00, 12'hB00, 32'h0, rd, ill);
    n_total++; if (rd !== v) $display("FAIL mcycle_inhibit got %h exp %h", rd, v); else n_pass++;
    csr_cycle(2'b01, 12'h320, 32'hFFFF_FFFF, rd, ill);
    csr_cycle(2'b01, 12'h320, 32'h0, rd, ill);
    n_total++; if (rd !== 32'h7D) $display("FAIL mcountinhibit_mask got %h exp 7d", rd); else n_pass++;
    @(negedge clk);
    retire = 1'b1; hpm_event = 4'b0001;
    repeat (2) @(posedge clk);
    #1 retire = 1'b0;
    @(posedge clk);
    #1 hpm_event = 4'b0000;
    csr_cycle(2'b00, 12'hB02, 32'h0, rd, ill);
    n_total++; if (rd !== 32'd2) $display("FAIL minstret got %0d exp 2", rd); else n_pass++;
    csr_cycle(2'b00, 12'hC03, 32'h0, rd, ill);
    n_total++; if (rd !== 32'd3 || ill !== 1'b0) $display("FAIL hpm3_user got %0d/%b exp 3/0", rd, ill); else n_pass++;
    csr_cycle(2'b00, 12'hB07, 32'h0, rd, ill);
    n_total++; if (rd !== 32'd0 || ill !== 1'b0) $display("FAIL hpm7_absent got %0d/%b exp 0/0", rd, ill); else n_pass++;
  endtask

  task automatic test_trap_mret();
    logic [31:0] rd; logic ill;
    csr_cycle(2'b01, 12'h300, 32'h8, rd, ill);
    n_total++; if (mstatus !== 32'h1808) $display("FAIL mstatus_mie_set got %h exp 1808", mstatus); else n_pass++;
    @(negedge clk);
    trap = 1'b1; trap_epc = 32'h1003; trap_cause = 32'h8000_000B;
    @(posedge clk); #1 trap = 1'b0;
    n_total++; if (mepc !== 32'h1000) $display("FAIL trap_mepc got %h exp 1000", mepc); else n_pass++;
    n_total++; if (mstatus !== 32'h1880) $display("FAIL trap_mstatus got %h exp 1880", mstatus); else n_pass++;
    csr_cycle(2'b00, 12'h342, 32'h0, rd, ill);
    n_total++; if (rd !== 32'h8000_000B) $display("FAIL trap_mcause got %h exp 8000000b", rd); else n_pass++;
    @(negedge clk);
    mret = 1'b1; csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h300; csr_wdata = 32'h0;
    @(posedge clk); #1 mret = 1'b0; csr_req = 1'b0;
    n_total++; if (mstatus !== 32'h1888) $display("FAIL mret_mstatus got %h exp 1888", mstatus); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    trap = 1'b1; mret = 1'b1; trap_epc = 32'h2002; trap_cause = 32'h2;
    csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h7770;
    @(posedge clk); #1 trap = 1'b0; mret = 1'b0; csr_req = 1'b0;
    n_total++; if (mstatus !== 32'h1880) $display("FAIL trap_mret_mstatus got %h exp 1880", mstatus); else n_pass++;
    n_total++; if (mepc !== 32'h2000) $display("FAIL trap_over_write_mepc got %h exp 2000", mepc); else n_pass++;
  endtask

  task automatic test_small_build();
    @(negedge clk);
    csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'hB80; #1;
    n_total++; if (rdata2 !== 32'h0 || illegal2 !== 1'b0) $display("FAIL small_mcycleh got %h/%b exp 0/0", rdata2, illegal2); else n_pass++;
    csr_addr = 12'hB03; #1;
    n_total++; if (rdata2 !== 32'h0 || illegal2 !== 1'b0) $display("FAIL small_hpm3 got %h/%b exp 0/0", rdata2, illegal2); else n_pass++;
    csr_op = 2'b01; csr_addr = 12'hB83; csr_wdata = 32'h5; #1;
    n_total++; if (illegal2 !== 1'b0) $display("FAIL small_hpmh_wr got %b exp 0", illegal2); else n_pass++;
    @(posedge clk); #1 csr_op = 2'b00;
    n_total++; if (rdata2 !== 32'h0) $display("FAIL small_hpmh_ignored got %h exp 0", rdata2); else n_pass++;
    csr_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mie();
    test_illegal();
    test_counters();
    test_trap_mret();
    test_back_to_back();
    test_small_build();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
